// File: rtl/trng_pkg.sv
// rtl/trng_pkg.sv - shared state encoding and default sizing for the TRNG sequencer
// Contents:
//   trng_state_e      FSM state encoding (IDLE=00, FLUSH=01, COLLECT=10, READY=11)
//   VEC_W_DEF         default output word width
//   FLUSH_CYCLES_DEF  default flush length per source (re)selection
//   TIMEOUT_LIMIT     idle COLLECT cycles before the optional timeout fires
package trng_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'b00,
    ST_FLUSH   = 2'b01,
    ST_COLLECT = 2'b10,
    ST_READY   = 2'b11
  } trng_state_e;

  localparam int unsigned VEC_W_DEF        = 8;
  localparam int unsigned FLUSH_CYCLES_DEF = 4;
  localparam int unsigned TIMEOUT_LIMIT    = 255;

endpackage

// File: rtl/req_edge_detect.sv
// rtl/req_edge_detect.sv - request qualification (rising edge or level)
// Ports:
//   clk        system clock
//   rst_n      asynchronous active-low reset
//   req_i      raw entropy request
//   req_ss_i   1 = single-shot (rising edge), 0 = level request
//   req_evt_o  qualified request event, valid in the current cycle
module req_edge_detect (
  input  logic clk,
  input  logic rst_n,
  input  logic req_i,
  input  logic req_ss_i,
  output logic req_evt_o
);

  logic req_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      req_q <= 1'b0;
    end else begin
      req_q <= req_i;
    end
  end

  // Mode is sampled every cycle, so switching req_ss takes effect immediately.
  assign req_evt_o = req_ss_i ? (req_i & ~req_q) : req_i;

endmodule

// File: rtl/trng_sequencer.sv
// rtl/trng_sequencer.sv - entropy source sequencer: flush, collect and publish random words
// Ports:
//   clk, rst_n    clock and asynchronous active-low reset
//   req, req_ss   entropy request and its mode (1 = rising edge, 0 = level)
//   src_sel       requested entropy source
//   bit_in        debiased entropy bit, qualified by bit_valid
//   sel_out       latched source select driving the source mux
//   flush         debiaser/pipeline clear
//   vector        last completed random word
//   vector_valid  vector is fresh and unconsumed
//   state         FSM state (IDLE=00, FLUSH=01, COLLECT=10, READY=11)
//   timeout       sticky collection-timeout flag
// Build option: TRNG_SEQ_TIMEOUT_EN adds an idle watchdog on COLLECT.
module trng_sequencer
  import trng_pkg::*;
#(
  parameter int unsigned VEC_W        = VEC_W_DEF,
  parameter int unsigned FLUSH_CYCLES = FLUSH_CYCLES_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req,
  input  logic             req_ss,
  input  logic [1:0]       src_sel,
  input  logic             bit_in,
  input  logic             bit_valid,
  output logic [1:0]       sel_out,
  output logic             flush,
  output logic [VEC_W-1:0] vector,
  output logic             vector_valid,
  output logic [1:0]       state,
  output logic             timeout
);

  localparam int CNT_W  = $clog2(VEC_W + 1);
  localparam int FCNT_W = $clog2(FLUSH_CYCLES + 1);
  localparam logic [FCNT_W-1:0] FLUSH_RELOAD = FCNT_W'(FLUSH_CYCLES - 1);
  localparam logic [CNT_W-1:0]  LAST_BIT     = CNT_W'(VEC_W - 1);

  trng_state_e       state_q;
  logic [1:0]        sel_q;
  logic              flush_q;
  logic [FCNT_W-1:0] fcnt_q;
  logic [VEC_W-1:0]  shift_q;
  logic [CNT_W-1:0]  bcnt_q;
  logic [VEC_W-1:0]  vec_q;
  logic              vvalid_q;
  logic              req_evt;
  logic              src_chg;
  logic [VEC_W-1:0]  shift_d;

  req_edge_detect u_req_edge_detect (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_i     (req),
    .req_ss_i  (req_ss),
    .req_evt_o (req_evt)
  );

  assign src_chg = (src_sel != sel_q);
  assign shift_d = {shift_q[VEC_W-2:0], bit_in};

`ifdef TRNG_SEQ_TIMEOUT_EN
  logic       timeout_q;
  logic [7:0] idle_cnt_q;
  assign timeout = timeout_q;
`else
  assign timeout = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      sel_q    <= 2'b00;
      flush_q  <= 1'b0;
      fcnt_q   <= '0;
      shift_q  <= '0;
      bcnt_q   <= '0;
      vec_q    <= '0;
      vvalid_q <= 1'b0;
`ifdef TRNG_SEQ_TIMEOUT_EN
      timeout_q  <= 1'b0;
      idle_cnt_q <= 8'd0;
`endif
    end else begin
      case (state_q)
        ST_IDLE, ST_READY: begin
          if (req_evt) begin
            state_q  <= ST_FLUSH;
            sel_q    <= src_sel;
            flush_q  <= 1'b1;
            fcnt_q   <= FLUSH_RELOAD;
            vvalid_q <= 1'b0;
            shift_q  <= '0;
            bcnt_q   <= '0;
`ifdef TRNG_SEQ_TIMEOUT_EN
            timeout_q <= 1'b0;
`endif
          end
        end
        ST_FLUSH: begin
          shift_q <= '0;
          bcnt_q  <= '0;
          if (src_chg) begin
            // Restart the flush window from the beginning for the new source.
            sel_q  <= src_sel;
            fcnt_q <= FLUSH_RELOAD;
          end else if (fcnt_q == '0) begin
            state_q <= ST_COLLECT;
            flush_q <= 1'b0;
`ifdef TRNG_SEQ_TIMEOUT_EN
            idle_cnt_q <= 8'd0;
`endif
          end else begin
            fcnt_q <= fcnt_q - FCNT_W'(1);
          end
        end
        ST_COLLECT: begin
          // A source change outranks a valid bit, including the word-completing one.
          if (src_chg) begin
            state_q <= ST_FLUSH;
            sel_q   <= src_sel;
            flush_q <= 1'b1;
            fcnt_q  <= FLUSH_RELOAD;
            shift_q <= '0;
            bcnt_q  <= '0;
          end else if (bit_valid) begin
            shift_q <= shift_d;
`ifdef TRNG_SEQ_TIMEOUT_EN
            idle_cnt_q <= 8'd0;
`endif
            if (bcnt_q == LAST_BIT) begin
              vec_q    <= shift_d;
              vvalid_q <= 1'b1;
              state_q  <= ST_READY;
              bcnt_q   <= '0;
            end else begin
              bcnt_q <= bcnt_q + CNT_W'(1);
            end
          end
`ifdef TRNG_SEQ_TIMEOUT_EN
          else if (idle_cnt_q == 8'(TIMEOUT_LIMIT - 1)) begin
            timeout_q  <= 1'b1;
            state_q    <= ST_IDLE;
            shift_q    <= '0;
            bcnt_q     <= '0;
            idle_cnt_q <= 8'd0;
          end else begin
            idle_cnt_q <= idle_cnt_q + 8'd1;
          end
`endif
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign sel_out      = sel_q;
  assign flush        = flush_q;
  assign vector       = vec_q;
  assign vector_valid = vvalid_q;
  assign state        = state_q;

endmodule

// File: tb/tb_trng_sequencer.sv
// tb/tb_trng_sequencer.sv - scoreboard bench for trng_sequencer (TRNG_SEQ_TIMEOUT_EN selects the timeout scenario)
module tb_trng_sequencer;

  localparam int VW = 8;
  localparam int FC = 4;

  logic       clk = 1'b0;
  logic       rst_n, req, req_ss, bit_in, bit_valid;
  logic [1:0] src_sel;
  logic [1:0] sel_out, state;
  logic       flush, vector_valid, timeout;
  logic [7:0] vector;

  int total = 0;
  int bad   = 0;

  logic [7:0] exp_q[$];
  logic [7:0] shadow    = 8'h00;
  logic [7:0] last_word = 8'h00;
  logic       vv_prev   = 1'b0;

  trng_sequencer #(.VEC_W(VW), .FLUSH_CYCLES(FC)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .req          (req),
    .req_ss       (req_ss),
    .src_sel      (src_sel),
    .bit_in       (bit_in),
    .bit_valid    (bit_valid),
    .sel_out      (sel_out),
    .flush        (flush),
    .vector       (vector),
    .vector_valid (vector_valid),
    .state        (state),
    .timeout      (timeout)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: every fresh vector_valid pops the oldest expected word; otherwise
  // the published vector must stay at the last completed word.
  always @(negedge clk) begin
    if (!rst_n) begin
      shadow  = 8'h00;
      vv_prev = 1'b0;
      exp_q.delete();
    end else begin
      if (vector_valid && !vv_prev) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_word", 32'(vector_valid), 32'd0);
        end else begin
          shadow = exp_q.pop_front();
          chk("word", 32'(vector), 32'(shadow));
        end
      end else begin
        chk("vector_hold", 32'(vector), 32'(shadow));
      end
      vv_prev = vector_valid;
    end
  end

  // Flush window: FC cycles of flush with the new source, junk bits ignored.
  task automatic flush_phase(input logic [1:0] sel);
    for (int i = 0; i < FC; i++) begin
      @(negedge clk);
      if (i == 0) begin
        if (req_ss) req = 1'b0;
        chk("timeout_clear", 32'(timeout), 32'd0);
      end
      chk("flush_hi", 32'(flush), 32'd1);
      chk("flush_state", 32'(state), 32'd1);
      chk("sel_out", 32'(sel_out), 32'(sel));
      chk("vv_low_in_flush", 32'(vector_valid), 32'd0);
      bit_valid = 1'($urandom_range(0, 1));
      bit_in    = 1'($urandom_range(0, 1));
    end
    @(negedge clk);
    bit_valid = 1'b0;
    chk("flush_lo", 32'(flush), 32'd0);
    chk("collect_state", 32'(state), 32'd2);
  endtask

  task automatic feed_bit(input logic b, input bit gaps);
    int n;
    n = gaps ? int'($urandom_range(0, 2)) : 0;
    for (int g = 0; g < n; g++) begin
      bit_valid = 1'b0;
      bit_in    = 1'($urandom_range(0, 1));
      if (req_ss) req = 1'($urandom_range(0, 1));
      @(negedge clk);
      chk("collecting", 32'(state), 32'd2);
    end
    bit_valid = 1'b1;
    bit_in    = b;
    if (req_ss) req = 1'b0;
    @(negedge clk);
    bit_valid = 1'b0;
  endtask

  task automatic partial(input int n, input bit gaps);
    for (int i = 0; i < n; i++) feed_bit(1'($urandom_range(0, 1)), gaps);
  endtask

  // Full word: first bit lands in the MSB, so the word is sum of bit * 2^(VW-1-i).
  task automatic collect_word(input logic [7:0] pat, input bit use_pat, input bit gaps);
    int   w;
    logic b;
    w = 0;
    for (int i = 0; i < VW; i++) begin
      b = use_pat ? pat[VW-1-i] : 1'($urandom_range(0, 1));
      w = (w * 2 + int'(b)) % 256;
      if (i == VW - 1) exp_q.push_back(8'(w));
      feed_bit(b, gaps);
    end
    chk("vv_latency", 32'(vector_valid), 32'd1);
    chk("ready_state", 32'(state), 32'd3);
    last_word = 8'(w);
  endtask

  task automatic do_word(input logic [1:0] sel, input logic ss, input bit gaps,
                         input logic [7:0] pat, input bit use_pat);
    req_ss  = ss;
    src_sel = sel;
    req     = 1'b1;
    flush_phase(sel);
    collect_word(pat, use_pat, gaps);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_state"}, 32'(state), 32'd0);
    chk({tag, "_sel"}, 32'(sel_out), 32'd0);
    chk({tag, "_flush"}, 32'(flush), 32'd0);
    chk({tag, "_vector"}, 32'(vector), 32'd0);
    chk({tag, "_vv"}, 32'(vector_valid), 32'd0);
    chk({tag, "_timeout"}, 32'(timeout), 32'd0);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [1:0] s, s2;
    rst_n = 1'b0; req = 1'b0; req_ss = 1'b1; src_sel = 2'd0;
    bit_in = 1'b0; bit_valid = 1'b0;
    repeat (2) @(negedge clk);
    chk_all_zero("reset");
    rst_n = 1'b1;
    @(negedge clk);
    chk("idle_after_reset", 32'(state), 32'd0);

    // Single-shot, source 2, fixed pattern.
    do_word(2'd2, 1'b1, 1'b0, 8'hB2, 1'b1);
    chk("vector_b2", 32'(vector), 32'hB2);
    repeat (3) begin
      @(negedge clk);
      chk("ready_hold", 32'(state), 32'd3);
      chk("ready_vv_hold", 32'(vector_valid), 32'd1);
    end

    // Level request held high: back-to-back words.
    for (int k = 0; k < 3; k++) do_word(2'(k + 1), 1'b0, 1'b0, 8'h00, 1'b0);
    req = 1'b0; req_ss = 1'b1;
    @(negedge clk);
    chk("ready_after_level", 32'(state), 32'd3);

    // Source change 1 -> 3 after five bits.
    req_ss = 1'b1; src_sel = 2'd1; req = 1'b1;
    flush_phase(2'd1);
    partial(5, 1'b1);
    src_sel = 2'd3; bit_valid = 1'b0; req = 1'b0;
    flush_phase(2'd3);
    collect_word(8'h00, 1'b0, 1'b1);

    // Source change coinciding with the final bit.
    src_sel = 2'd2; req = 1'b1;
    flush_phase(2'd2);
    partial(VW - 1, 1'b1);
    bit_valid = 1'b1; bit_in = 1'b1; src_sel = 2'd0; req = 1'b0;
    flush_phase(2'd0);
    chk("vector_kept", 32'(vector), 32'(last_word));
    collect_word(8'h00, 1'b0, 1'b1);

    // Randomised single-shot words, some interrupted by a source change.
    for (int r = 0; r < 20; r++) begin
      s = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 3) == 0) begin
        req_ss = 1'b1; src_sel = s; req = 1'b1;
        flush_phase(s);
        partial(int'($urandom_range(1, VW - 1)), 1'b1);
        s2 = s ^ 2'($urandom_range(1, 3));
        src_sel = s2; bit_valid = 1'($urandom_range(0, 1)); req = 1'b0;
        flush_phase(s2);
        collect_word(8'h00, 1'b0, 1'b1);
      end else begin
        do_word(s, 1'b1, 1'b1, 8'h00, 1'b0);
      end
    end

`ifdef TRNG_SEQ_TIMEOUT_EN
    req_ss = 1'b1; src_sel = 2'd1; req = 1'b1;
    flush_phase(2'd1);
    repeat (254) @(negedge clk);
    chk("no_timeout_yet", 32'(timeout), 32'd0);
    chk("still_collect", 32'(state), 32'd2);
    @(negedge clk);
    chk("timeout_set", 32'(timeout), 32'd1);
    chk("timeout_idle", 32'(state), 32'd0);
    chk("timeout_vv", 32'(vector_valid), 32'd0);
    do_word(2'd3, 1'b1, 1'b1, 8'h00, 1'b0);
`else
    req_ss = 1'b1; src_sel = 2'd1; req = 1'b1;
    flush_phase(2'd1);
    repeat (300) @(negedge clk);
    chk("wait_forever_state", 32'(state), 32'd2);
    chk("timeout_tied", 32'(timeout), 32'd0);
    src_sel = 2'd2;
    flush_phase(2'd2);
    collect_word(8'h00, 1'b0, 1'b1);
`endif

    // Reset in the middle of a word.
    src_sel = 2'd2; req = 1'b1;
    flush_phase(2'd2);
    partial(3, 1'b1);
    #2 rst_n = 1'b0;
    #1 chk_all_zero("async_reset");
    req = 1'b0; src_sel = 2'd0;
    repeat (2) @(negedge clk);
    #2 rst_n = 1'b1;
    last_word = 8'h00;
    repeat (3) begin
      @(negedge clk);
      chk("post_reset_vv", 32'(vector_valid), 32'd0);
      chk("post_reset_state", 32'(state), 32'd0);
      chk("post_reset_flush", 32'(flush), 32'd0);
    end
    do_word(2'd1, 1'b1, 1'b1, 8'h00, 1'b0);

    @(negedge clk);
    chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/trng_sequencer.md
TRNG_SEQUENCER -- requirements
Module: trng_sequencer

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset, named as in the codebase: clk and rst_n.
REQ-002 The block SHALL have parameter VEC_W, default 8, giving the output vector width in bits.
REQ-003 The block SHALL have parameter FLUSH_CYCLES, default 4, giving the number of cycles flush is held per source (re)selection.
REQ-004 The block SHALL have port clk, input, 1 bit: system clock.
REQ-005 The block SHALL have port rst_n, input, 1 bit: asynchronous active-low reset.
REQ-006 The block SHALL have port req, input, 1 bit: entropy request.
REQ-007 The block SHALL have port req_ss, input, 1 bit: 1 = single-shot (rising edge of req), 0 = level request.
REQ-008 The block SHALL have port src_sel, input, 2 bits: requested entropy source.
REQ-009 The block SHALL have port bit_in, input, 1 bit: debiased entropy bit.
REQ-010 The block SHALL have port bit_valid, input, 1 bit: bit_in qualifier.
REQ-011 The block SHALL have port sel_out, output, 2 bits: latched source select driving the source mux.
REQ-012 The block SHALL have port flush, output, 1 bit: debiaser/pipeline clear.
REQ-013 The block SHALL have port vector, output, VEC_W bits: last completed random word.
REQ-014 The block SHALL have port vector_valid, output, 1 bit: vector is fresh and unconsumed.
REQ-015 The block SHALL have port state, output, 2 bits: FSM state (IDLE=00, FLUSH=01, COLLECT=10, READY=11).
REQ-016 The block SHALL have port timeout, output, 1 bit: sticky collection-timeout flag.

Function
REQ-017 The request event SHALL be the registered rising edge of req when req_ss=1, and SHALL be req high when req_ss=0; req_ss SHALL be sampled every cycle.
REQ-018 In IDLE or READY, a request event SHALL latch src_sel into sel_out, clear vector_valid, and enter FLUSH the next cycle.
REQ-019 FLUSH SHALL assert flush for exactly FLUSH_CYCLES cycles, clear the shift register and bit counter, then enter COLLECT.
REQ-020 In COLLECT, each cycle with bit_valid=1 SHALL shift bit_in into the LSB of the shift register and increment the counter; bit_valid SHALL be ignored in all other states.
REQ-021 When the VEC_W-th bit is accepted, the shift register SHALL be copied to vector and vector_valid SHALL assert in the same transition to READY; the latency from that bit to vector_valid is 1 cycle.
REQ-022 vector SHALL change only on word completion; a partial word SHALL never be visible.
REQ-023 If src_sel differs from sel_out during FLUSH or COLLECT, the block SHALL discard the partial word, relatch sel_out, and restart FLUSH with a full FLUSH_CYCLES count.
REQ-024 If a source change coincides with the final bit, the source change SHALL win and the bit SHALL be discarded.
REQ-025 In READY with req_ss=0 and req held high, the block SHALL re-request the next cycle, giving back-to-back words.
REQ-026 In READY with req_ss=1, the block SHALL stay in READY until a new rising edge of req.
REQ-027 Request events in FLUSH or COLLECT SHALL be ignored and not queued.

Reset
REQ-028 Assertion of rst_n=0 SHALL asynchronously force state=IDLE, sel_out=0, vector=0, vector_valid=0, flush=0, timeout=0, counter=0, shift register=0, and the registered req value=0.
REQ-029 Reset mid-collection SHALL discard the partial word, with no output pulse on release.

Configuration
REQ-030 With TRNG_SEQ_TIMEOUT_EN defined, an 8-bit idle counter SHALL count COLLECT cycles with bit_valid=0 and reset to 0 on each accepted bit.
REQ-031 With TRNG_SEQ_TIMEOUT_EN defined, when the idle counter reaches 255 the block SHALL set timeout, discard the partial word and return to IDLE.
REQ-032 With TRNG_SEQ_TIMEOUT_EN defined, timeout SHALL clear on the next accepted request event.
REQ-033 Without TRNG_SEQ_TIMEOUT_EN, timeout SHALL be tied to 0, no idle counter SHALL exist, and COLLECT SHALL wait indefinitely.

Structure
REQ-034 The state encoding, the default VEC_W and FLUSH_CYCLES values, and TIMEOUT_LIMIT=255 SHALL reside in the shared package trng_pkg.
REQ-035 Request edge/level qualification SHALL be a sub-module, req_edge_detect; all other logic SHALL be in trng_sequencer.

Verification
REQ-036 Bench: reset, req_ss=1, pulse req, src_sel=2, feed bits 1,0,1,1,0,0,1,0 -> flush high 4 cycles, sel_out=2, vector=8'hB2, vector_valid=1 one cycle after the 8th bit.
REQ-037 Bench: req_ss=0, req held high, continuous bit_valid -> consecutive words each preceded by 4 flush cycles, with vector_valid low between words.
REQ-038 Bench: src_sel change 1 to 3 after 5 bits -> flush re-asserted, sel_out=3, and the next vector contains only post-change bits.
REQ-039 Bench: src_sel change in the same cycle as the 8th bit -> no READY, state=FLUSH, vector unchanged.
REQ-040 Bench: rst_n low mid-COLLECT -> all outputs 0 immediately, state=00.
REQ-041 Bench: with TRNG_SEQ_TIMEOUT_EN defined, bit_valid=0 for 255 COLLECT cycles -> timeout=1, state=IDLE; the next req clears timeout.
